cpu_run_ctrl: RTL and testbench

Program-load and run sequencer for the five-stage MIPS `cpu`. It owns the instruction store and accepts a program over a valid/ready load stream. On `start` it flushes the pipeline, gates `pcEn` while it feeds instructions by PC, detects a halt word or runaway, and drains the pipeline before reporting completion. It sits between the host/test harness and the `cpu` instance, driving `cpu.inst`, `cpu.pcEn` and `cpu.reset` and observing `cpu.pc`.

---
 rtl/mips_ctrl_pkg.sv | 16 +
 rtl/prog_ram.sv | 24 ++
 rtl/cpu_run_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_cpu_run_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared types and constants for the MIPS program-load and run sequencer.
package mips_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_FLUSH = 3'd2,
        ST_RUN   = 3'd3,
        ST_DRAIN = 3'd4,
        ST_DONE  = 3'd5
    } run_state_t;

    localparam logic [31:0] NOP_INST          = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_HALT_INST = 32'hFFFF_FFFF;

endpackage

// File: rtl/prog_ram.sv
// Instruction store: one synchronous write port, one asynchronous read port, no reset.
module prog_ram #(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/cpu_run_ctrl.sv
// Program-load and run sequencer for the five-stage MIPS cpu: loads the instruction
// store, flushes the pipeline, feeds instructions by PC, detects halt/runaway and drains.
module cpu_run_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int          DEPTH        = 64,
    parameter int          FLUSH_CYCLES = 3,
    parameter int          DRAIN_CYCLES = 4,
    parameter int          MAX_CYCLES   = 1024,
    parameter logic [31:0] HALT_INST    = DEFAULT_HALT_INST,
    localparam int         AW           = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ld_valid,
    output logic          ld_ready,
    input  logic [31:0]   ld_data,
    input  logic          ld_last,
    input  logic          start,
    input  logic [31:0]   cpu_pc,
    output logic [31:0]   cpu_inst,
    output logic          cpu_pc_en,
    output logic          cpu_reset,
    output logic          busy,
    output logic          done,
    output logic          timeout,
    output logic [AW:0]   prog_len,
    output logic [31:0]   cycle_count
);

    localparam int LW        = AW + 1;
    localparam int PHASE_MAX = (FLUSH_CYCLES > DRAIN_CYCLES) ? FLUSH_CYCLES : DRAIN_CYCLES;
    localparam int PW        = (PHASE_MAX > 1) ? $clog2(PHASE_MAX) : 1;

    localparam logic [PW-1:0] FLUSH_LAST = PW'(FLUSH_CYCLES - 1);
    localparam logic [PW-1:0] DRAIN_LAST = PW'(DRAIN_CYCLES - 1);
    localparam logic [AW-1:0] LAST_IDX   = AW'(DEPTH - 1);
    localparam logic [31:0]   WD_LAST    = 32'(MAX_CYCLES - 1);

    run_state_t    state, next_state;
    logic [AW-1:0] wr_ptr;
    logic [PW-1:0] phase_cnt;

    logic [AW-1:0] idx;
    logic [AW-1:0] ram_waddr;
    logic [31:0]   ram_rdata;
    logic          ld_accept;
    logic          load_end;
    logic          start_ok;
    logic          hit;
    logic          watchdog;
    logic          pc_low_unused;

    // The CPU fetches word-aligned, so the byte-offset bits carry no information.
    assign pc_low_unused = ^cpu_pc[1:0];

    assign idx       = cpu_pc[AW+1:2];
    assign ld_accept = ld_valid && ld_ready;
    assign ram_waddr = (state == ST_LOAD) ? wr_ptr : '0;
    assign load_end  = ld_last || (state == ST_LOAD && wr_ptr == LAST_IDX);
    assign start_ok  = start && (prog_len != '0) && !ld_accept;
    assign watchdog  = (cycle_count == WD_LAST);

    // Any fetch outside the loaded program, or of the halt word, ends the run.
    assign hit = (|cpu_pc[31:AW+2]) || ({1'b0, idx} >= prog_len) || (ram_rdata == HALT_INST);

    prog_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_prog_ram (
        .clk   (clk),
        .we    (ld_accept),
        .waddr (ram_waddr),
        .wdata (ld_data),
        .raddr (idx),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            wr_ptr      <= '0;
            prog_len    <= '0;
            cycle_count <= '0;
            timeout     <= 1'b0;
            phase_cnt   <= '0;
        end else begin
            state <= next_state;
            unique case (state)
                ST_IDLE, ST_DONE: begin
                    if (ld_accept) begin
                        timeout  <= 1'b0;
                        wr_ptr   <= ld_last ? '0 : AW'(1);
                        prog_len <= ld_last ? LW'(1) : '0;
                    end else if (start_ok) begin
                        cycle_count <= '0;
                        timeout     <= 1'b0;
                        phase_cnt   <= '0;
                    end
                end
                ST_LOAD: begin
                    if (ld_accept) begin
                        if (load_end) begin
                            wr_ptr   <= '0;
                            prog_len <= LW'(wr_ptr) + LW'(1);
                        end else begin
                            wr_ptr <= wr_ptr + AW'(1);
                        end
                    end
                end
                ST_FLUSH: begin
                    phase_cnt <= (phase_cnt == FLUSH_LAST) ? '0 : phase_cnt + PW'(1);
                end
                ST_RUN: begin
                    cycle_count <= cycle_count + 32'd1;
                    phase_cnt   <= '0;
                    // A halt in the watchdog cycle is a clean finish, not a timeout.
                    if (!hit && watchdog) begin
                        timeout <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    phase_cnt <= phase_cnt + PW'(1);
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        next_state = state;
        cpu_inst   = NOP_INST;
        cpu_pc_en  = 1'b0;
        cpu_reset  = reset;
        busy       = 1'b0;
        done       = 1'b0;
        ld_ready   = 1'b0;
        unique case (state)
            ST_IDLE, ST_DONE: begin
                ld_ready = !reset;
                done     = (state == ST_DONE);
                if (ld_accept) begin
                    next_state = ld_last ? ST_IDLE : ST_LOAD;
                end else if (start_ok) begin
                    next_state = ST_FLUSH;
                end
            end
            ST_LOAD: begin
                ld_ready = !reset;
                if (ld_accept && load_end) begin
                    next_state = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                busy      = 1'b1;
                cpu_reset = 1'b1;
                if (phase_cnt == FLUSH_LAST) begin
                    next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                busy      = 1'b1;
                cpu_inst  = hit ? NOP_INST : ram_rdata;
                cpu_pc_en = !hit;
                if (hit || watchdog) begin
                    next_state = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                busy = 1'b1;
                if (phase_cnt == DRAIN_LAST) begin
                    next_state = ST_DONE;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Self-checking bench for cpu_run_ctrl: a toy harness CPU steps the PC, and a
// reference model walks the loaded program to predict each run.
module tb_cpu_run_ctrl;

    localparam int          DEPTH        = 64;
    localparam int          FLUSH_CYCLES = 3;
    localparam int          DRAIN_CYCLES = 4;
    localparam int          MAX_CYCLES   = 16;
    localparam int          AW           = 6;
    localparam logic [31:0] HALT         = 32'hFFFF_FFFF;
    localparam logic [31:0] ADDI         = 32'h2000_0000;
    localparam logic [31:0] J0           = 32'h0800_0000;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          ld_valid = 1'b0;
    logic          ld_ready;
    logic [31:0]   ld_data = '0;
    logic          ld_last = 1'b0;
    logic          start = 1'b0;
    logic [31:0]   cpu_pc = '0;
    logic [31:0]   cpu_inst;
    logic          cpu_pc_en;
    logic          cpu_reset;
    logic          busy;
    logic          done;
    logic          timeout;
    logic [AW:0]   prog_len;
    logic [31:0]   cycle_count;

    int checks = 0;
    int errors = 0;

    logic [31:0] load_buf [70];
    logic [31:0] ref_mem  [DEPTH];
    int          ref_len = 0;
    int          ref_ptr = 0;

    logic [31:0] exp_inst_q [$];
    bit          exp_en_q   [$];
    int          exp_cycles;
    bit          exp_timeout;
    logic [31:0] exp_pc;

    cpu_run_ctrl #(
        .DEPTH        (DEPTH),
        .FLUSH_CYCLES (FLUSH_CYCLES),
        .DRAIN_CYCLES (DRAIN_CYCLES),
        .MAX_CYCLES   (MAX_CYCLES),
        .HALT_INST    (HALT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ld_valid    (ld_valid),
        .ld_ready    (ld_ready),
        .ld_data     (ld_data),
        .ld_last     (ld_last),
        .start       (start),
        .cpu_pc      (cpu_pc),
        .cpu_inst    (cpu_inst),
        .cpu_pc_en   (cpu_pc_en),
        .cpu_reset   (cpu_reset),
        .busy        (busy),
        .done        (done),
        .timeout     (timeout),
        .prog_len    (prog_len),
        .cycle_count (cycle_count)
    );

    always #5 clk = ~clk;

    // Toy CPU: only "j" redirects the PC, everything else falls through.
    function automatic logic [31:0] next_pc(input logic [31:0] pc, input logic [31:0] w);
        if (w[31:26] == 6'h02) return {pc[31:28], w[25:0], 2'b00};
        return pc + 32'd4;
    endfunction

    always @(posedge clk) begin
        if (cpu_reset) cpu_pc <= '0;
        else if (cpu_pc_en) cpu_pc <= next_pc(cpu_pc, cpu_inst);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Walks the stored program from PC 0 the way the run should unfold.
    function automatic void model_run();
        logic [31:0] pc = '0;
        logic [31:0] w;
        bit          h;
        exp_inst_q.delete();
        exp_en_q.delete();
        exp_timeout = 1'b0;
        exp_cycles  = 0;
        for (int n = 1; n <= MAX_CYCLES; n++) begin
            w = '0;
            h = 1'b1;
            if (pc < 32'(4 * DEPTH) && int'(pc / 4) < ref_len) begin
                w = ref_mem[pc / 4];
                h = (w == HALT);
            end
            exp_inst_q.push_back(h ? 32'h0 : w);
            exp_en_q.push_back(!h);
            exp_cycles = n;
            if (h) break;
            pc = next_pc(pc, w);
            if (n == MAX_CYCLES) exp_timeout = 1'b1;
        end
        exp_pc = pc;
    endfunction

    task automatic apply_stimulus(input int n, input bit gaps, input bit poke_start);
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                ld_valid = 1'b0;
                start    = 1'b0;
                tick();
            end
            ld_valid = 1'b1;
            ld_data  = load_buf[i];
            ld_last  = (i == n - 1);
            start    = poke_start && (i == 1);
            check_output("ld_ready_load", 32'(ld_ready), 32'd1);
            tick();
            if (ref_ptr == 0) ref_len = 0;
            ref_mem[ref_ptr] = load_buf[i];
            ref_ptr++;
            if (ld_last || ref_ptr == DEPTH) begin
                ref_len = ref_ptr;
                ref_ptr = 0;
                if (i != n - 1) check_output("prog_len_full", 32'(prog_len), 32'(ref_len));
            end
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        start    = 1'b0;
        check_output("busy_after_load", 32'(busy), 32'd0);
        check_output("prog_len", 32'(prog_len), 32'(ref_len));
    endtask

    task automatic run_and_check(input bit poke_drain);
        model_run();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int f = 0; f < FLUSH_CYCLES; f++) begin
            check_output("flush_cpu_reset", 32'(cpu_reset), 32'd1);
            check_output("flush_busy", 32'(busy), 32'd1);
            check_output("flush_ld_ready", 32'(ld_ready), 32'd0);
            check_output("flush_pc_en", 32'(cpu_pc_en), 32'd0);
            if (f == 0) begin
                check_output("flush_cycle_count", cycle_count, 32'd0);
                check_output("flush_done", 32'(done), 32'd0);
                check_output("flush_timeout", 32'(timeout), 32'd0);
            end
            tick();
        end
        for (int k = 0; k < exp_cycles; k++) begin
            check_output("run_inst", cpu_inst, exp_inst_q[k]);
            check_output("run_pc_en", 32'(cpu_pc_en), 32'(exp_en_q[k]));
            check_output("run_cpu_reset", 32'(cpu_reset), 32'd0);
            tick();
        end
        for (int d = 0; d < DRAIN_CYCLES; d++) begin
            check_output("drain_pc_en", 32'(cpu_pc_en), 32'd0);
            check_output("drain_inst", cpu_inst, 32'd0);
            check_output("drain_busy", 32'(busy), 32'd1);
            check_output("drain_done", 32'(done), 32'd0);
            start = poke_drain && (d == 1);
            tick();
            start = 1'b0;
        end
        check_output("done", 32'(done), 32'd1);
        check_output("done_busy", 32'(busy), 32'd0);
        check_output("done_ld_ready", 32'(ld_ready), 32'd1);
        check_output("timeout", 32'(timeout), 32'(exp_timeout));
        check_output("cycle_count", cycle_count, 32'(exp_cycles));
        check_output("final_pc", cpu_pc, exp_pc);
    endtask

    initial begin
        int          n;
        int          r;
        $display("[TB] cpu_run_ctrl bench starting");

        reset = 1'b1;
        tick();
        tick();
        check_output("rst_ld_ready", 32'(ld_ready), 32'd0);
        check_output("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_done", 32'(done), 32'd0);
        check_output("rst_timeout", 32'(timeout), 32'd0);
        check_output("rst_prog_len", 32'(prog_len), 32'd0);
        check_output("rst_cycle_count", cycle_count, 32'd0);
        check_output("rst_pc_en", 32'(cpu_pc_en), 32'd0);
        check_output("rst_inst", cpu_inst, 32'd0);
        reset = 1'b0;
        tick();
        check_output("idle_cpu_reset", 32'(cpu_reset), 32'd0);
        check_output("idle_ld_ready", 32'(ld_ready), 32'd1);

        // start with nothing loaded must be ignored
        start = 1'b1;
        tick();
        start = 1'b0;
        check_output("empty_start_busy", 32'(busy), 32'd0);
        check_output("empty_start_cpu_reset", 32'(cpu_reset), 32'd0);

        // four plain words, run falls off the end at PC 16
        for (int i = 0; i < 4; i++) load_buf[i] = ADDI | 32'(i + 1);
        apply_stimulus(4, 1'b0, 1'b1);
        check_output("tp1_prog_len", 32'(prog_len), 32'd4);
        run_and_check(1'b0);
        check_output("tp1_cycles", cycle_count, 32'd5);

        // addi then halt: PC freezes on the halt address
        load_buf[0] = ADDI | 32'h5;
        load_buf[1] = HALT;
        apply_stimulus(2, 1'b0, 1'b0);
        run_and_check(1'b0);
        check_output("tp2_pc", cpu_pc, 32'd4);
        check_output("tp2_timeout", 32'(timeout), 32'd0);

        // endless j 0, start poked during drain, then rerun from DONE
        load_buf[0] = J0;
        apply_stimulus(1, 1'b0, 1'b0);
        run_and_check(1'b1);
        check_output("tp3_timeout", 32'(timeout), 32'd1);
        check_output("tp3_cycles", cycle_count, 32'd16);
        run_and_check(1'b0);

        // halt exactly in the watchdog cycle wins over the timeout
        for (int i = 0; i < 15; i++) load_buf[i] = ADDI | 32'(i);
        load_buf[15] = HALT;
        apply_stimulus(16, 1'b1, 1'b0);
        run_and_check(1'b0);
        check_output("wd_tie_timeout", 32'(timeout), 32'd0);

        // sixteen plain words: watchdog fires before the end-of-program fetch
        load_buf[15] = ADDI;
        apply_stimulus(16, 1'b0, 1'b0);
        run_and_check(1'b0);
        check_output("wd_timeout", 32'(timeout), 32'd1);

        // 70 words: index 63 closes the first load, the rest form a new program
        for (int i = 0; i < 70; i++) load_buf[i] = ADDI | 32'(i);
        load_buf[69] = HALT;
        apply_stimulus(70, 1'b0, 1'b0);
        check_output("tp4_prog_len", 32'(prog_len), 32'd6);
        run_and_check(1'b0);
        check_output("tp4_cycles", cycle_count, 32'd6);

        // reset in RUN cycle 5 discards the program
        load_buf[0] = J0;
        apply_stimulus(1, 1'b0, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < FLUSH_CYCLES + 4; i++) tick();
        check_output("mid_run_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check_output("mid_rst_ld_ready", 32'(ld_ready), 32'd0);
        check_output("mid_rst_cpu_reset", 32'(cpu_reset), 32'd1);
        tick();
        reset   = 1'b0;
        ref_len = 0;
        ref_ptr = 0;
        #1;
        check_output("mid_rst_busy", 32'(busy), 32'd0);
        check_output("mid_rst_prog_len", 32'(prog_len), 32'd0);
        check_output("mid_rst_cycle_count", cycle_count, 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_output("mid_rst_start_busy", 32'(busy), 32'd0);
        check_output("mid_rst_start_cpu_reset", 32'(cpu_reset), 32'd0);

        // random programs of plain words, halts, short and far jumps
        for (int t = 0; t < 10; t++) begin
            n = $urandom_range(1, 10);
            for (int i = 0; i < n; i++) begin
                r = $urandom_range(0, 9);
                if (r <= 5)      load_buf[i] = ADDI | ($urandom & 32'h03FF_FFFF);
                else if (r == 6) load_buf[i] = HALT;
                else if (r == 7) load_buf[i] = {6'h02, 26'($urandom_range(0, 11))};
                else if (r == 8) load_buf[i] = {6'h02, 26'(32'h100 + $urandom_range(0, 255))};
                else             load_buf[i] = $urandom;
            end
            apply_stimulus(n, 1'b1, (n > 1) && (t % 3 == 0));
            run_and_check(t % 4 == 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed=stalled expected=finished");
        $fatal(1, "[TB] simulation time limit exceeded");
    end

endmodule
